// File: rtl/vector_main_decoder_if.sv
// Decode/control bundle between the front end and vector_main_decoder.
// master = front end / memory side, slave = decoder.
interface vector_main_decoder_if #(
  parameter int LW = 2
);
  logic          instr_valid;
  logic [2:0]    Opcode;
  logic          V;
  logic [2:0]    Funct;
  logic          mem_ready;
  logic          Branch;
  logic          MemtoReg;
  logic          MemW;
  logic          ALUSrc;
  logic          RegW;
  logic          ALUOp;
  logic [1:0]    ImmSrc;
  logic [LW-1:0] Lane;
  logic          VecActive;
  logic          Stall;
  logic          Done;
  logic          Illegal;

  modport master (
    output instr_valid, Opcode, V, Funct, mem_ready,
    input  Branch, MemtoReg, MemW, ALUSrc, RegW, ALUOp, ImmSrc,
           Lane, VecActive, Stall, Done, Illegal
  );

  modport slave (
    input  instr_valid, Opcode, V, Funct, mem_ready,
    output Branch, MemtoReg, MemW, ALUSrc, RegW, ALUOp, ImmSrc,
           Lane, VecActive, Stall, Done, Illegal
  );
endinterface

// File: rtl/vector_main_decoder.sv
// Main decoder: single-cycle scalar decode, multi-cycle vector lane sequencer.
// Optional macro VEC_ABORT_EN adds an 'abort' input that kills a running sequence.
module vector_main_decoder #(
  parameter int LANES = 4,
  parameter int PAR   = 1,
  parameter int LW    = $clog2(LANES)
) (
  input  logic clk,
  input  logic rst,
`ifdef VEC_ABORT_EN
  input  logic abort,
`endif
  vector_main_decoder_if.slave bus
);

  localparam int            LWP     = LW + 1;
  localparam logic [LW-1:0] LAST    = LW'(LANES - 1);
  localparam logic [LW:0]   LANES_X = LWP'(LANES);
  localparam logic [LW:0]   PAR_X   = LWP'(PAR);

  typedef enum logic [1:0] {IDLE, VMEM, VALU, DONE} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          str_q, str_d;
  logic [1:0]    fn_q, fn_d;

  logic          br, mtr, mw, as, rw, ao, va, st, dn, il;
  logic [1:0]    imm;
  logic          launch, abort_w;
  logic [LW:0]   lane_sum;

`ifdef VEC_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Vector shifts (Funct=x11) are not sequenced; they decode as scalar shifts.
  assign launch = bus.V && ((bus.Opcode == 3'b001) || (bus.Opcode == 3'b010) ||
                            ((bus.Opcode == 3'b000) && (bus.Funct[1:0] != 2'b11)));

  assign lane_sum = {1'b0, lane_q} + PAR_X;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      str_q   <= 1'b0;
      fn_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      str_q   <= str_d;
      fn_q    <= fn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    str_d   = str_q;
    fn_d    = fn_q;
    br = 1'b0; mtr = 1'b0; mw = 1'b0; as = 1'b0; rw = 1'b0; ao = 1'b0;
    imm = 2'b00;
    va = 1'b0; st = 1'b0; dn = 1'b0; il = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          if (launch) begin
            st      = 1'b1;
            str_d   = (bus.Opcode == 3'b001);
            fn_d    = bus.Funct[1:0];
            lane_d  = '0;
            state_d = (bus.Opcode == 3'b000) ? VALU : VMEM;
          end else begin
            case (bus.Opcode)
              3'b000: begin
                rw = 1'b1;
                ao = 1'b1;
                if (bus.Funct[1:0] == 2'b11) begin
                  as  = 1'b1;
                  imm = 2'b11;
                end
              end
              3'b100, 3'b101, 3'b110: begin
                as = 1'b1;
                if (bus.V) begin
                  rw = 1'b1;
                  ao = 1'b1;
                end else begin
                  br = 1'b1;
                end
              end
              3'b111: begin
                br  = 1'b1;
                as  = 1'b1;
                imm = bus.V ? 2'b01 : 2'b00;
              end
              3'b001: begin
                mw = 1'b1;
                as = 1'b1;
              end
              3'b010: begin
                mtr = 1'b1;
                as  = 1'b1;
                rw  = 1'b1;
              end
              default: il = 1'b1;
            endcase
          end
        end
      end

      VMEM: begin
        va = 1'b1;
        st = 1'b1;
        as = 1'b1;
        if (str_q) mw = 1'b1;
        else begin
          mtr = 1'b1;
          rw  = bus.mem_ready;
        end
        if (abort_w) begin
          mw      = 1'b0;
          rw      = 1'b0;
          lane_d  = '0;
          state_d = IDLE;
        end else if (bus.mem_ready) begin
          if (lane_q == LAST) begin
            lane_d  = '0;
            state_d = DONE;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end

      VALU: begin
        va = 1'b1;
        st = 1'b1;
        rw = 1'b1;
        ao = 1'b1;
        if (fn_q == 2'b11) begin
          as  = 1'b1;
          imm = 2'b11;
        end
        // Exit on the beat that covers the last lane so Lane never wraps.
        if (abort_w) begin
          rw      = 1'b0;
          lane_d  = '0;
          state_d = IDLE;
        end else if (lane_sum == LANES_X) begin
          lane_d  = '0;
          state_d = DONE;
        end else begin
          lane_d = lane_sum[LW-1:0];
        end
      end

      DONE: begin
        dn      = 1'b1;
        lane_d  = '0;
        state_d = IDLE;
      end

      default: begin
        lane_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Reset cycles issue nothing, even mid-sequence.
  assign bus.Branch    = br  & ~rst;
  assign bus.MemtoReg  = mtr & ~rst;
  assign bus.MemW      = mw  & ~rst;
  assign bus.ALUSrc    = as  & ~rst;
  assign bus.RegW      = rw  & ~rst;
  assign bus.ALUOp     = ao  & ~rst;
  assign bus.ImmSrc    = imm & {2{~rst}};
  assign bus.Lane      = lane_q & {LW{~rst}};
  assign bus.VecActive = va  & ~rst;
  assign bus.Stall     = st  & ~rst;
  assign bus.Done      = dn  & ~rst;
  assign bus.Illegal   = il  & ~rst;

endmodule

// File: tb/tb_vector_main_decoder.sv
// Scoreboard bench: driver pushes expected control words, negedge monitor pops and compares.
// DUT a: LANES=4 PAR=1; DUT b: LANES=8 PAR=2.
module tb_vector_main_decoder;

  logic clk = 1'b0;
  logic rsta, rstb, aborta, abortb;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vector_main_decoder_if #(.LW(2)) ia ();
  vector_main_decoder_if #(.LW(3)) ib ();

  vector_main_decoder #(.LANES(4), .PAR(1)) dut_a (
    .clk(clk),
    .rst(rsta),
`ifdef VEC_ABORT_EN
    .abort(aborta),
`endif
    .bus(ia)
  );

  vector_main_decoder #(.LANES(8), .PAR(2)) dut_b (
    .clk(clk),
    .rst(rstb),
`ifdef VEC_ABORT_EN
    .abort(abortb),
`endif
    .bus(ib)
  );

  // {Branch,MemtoReg,MemW,ALUSrc,RegW,ALUOp, ImmSrc[1:0], Lane[2:0], VecActive,Stall,Done,Illegal}
  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] act;
    if (qa.size() > 0) begin
      e   = qa.pop_front();
      act = {ia.Branch, ia.MemtoReg, ia.MemW, ia.ALUSrc, ia.RegW, ia.ALUOp, ia.ImmSrc,
             1'b0, ia.Lane, ia.VecActive, ia.Stall, ia.Done, ia.Illegal};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL a.%s got %b expected %b", e.tag, act, e.v);
      end
    end
    if (qb.size() > 0) begin
      e   = qb.pop_front();
      act = {ib.Branch, ib.MemtoReg, ib.MemW, ib.ALUSrc, ib.RegW, ib.ALUOp, ib.ImmSrc,
             ib.Lane, ib.VecActive, ib.Stall, ib.Done, ib.Illegal};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL b.%s got %b expected %b", e.tag, act, e.v);
      end
    end
  end

  task automatic step(input bit sel, input bit rs, input bit iv, input logic [2:0] op,
                      input bit v, input logic [2:0] fn, input bit mr, input bit ab,
                      input logic [5:0] c, input logic [1:0] imm, input logic [2:0] ln,
                      input logic [3:0] f, input string tag);
    exp_t e;
    e.tag = tag;
    e.v   = {c, imm, ln, f};
    if (!sel) begin
      rsta = rs; ia.instr_valid = iv; ia.Opcode = op; ia.V = v; ia.Funct = fn;
      ia.mem_ready = mr; aborta = ab;
      qa.push_back(e);
    end else begin
      rstb = rs; ib.instr_valid = iv; ib.Opcode = op; ib.V = v; ib.Funct = fn;
      ib.mem_ready = mr; abortb = ab;
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rsta = 1'b1; rstb = 1'b1; aborta = 1'b0; abortb = 1'b0;
    ia.instr_valid = 1'b0; ia.Opcode = 3'b000; ia.V = 1'b0; ia.Funct = 3'b000; ia.mem_ready = 1'b0;
    ib.instr_valid = 1'b0; ib.Opcode = 3'b000; ib.V = 1'b0; ib.Funct = 3'b000; ib.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset held with a valid addi: everything gated off
    step(0, 1, 1, 3'b100, 1, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0000, "rst_gate");
    step(1, 1, 0, 3'b000, 0, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0000, "rst_b");
    step(0, 0, 0, 3'b100, 1, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0000, "idle_novalid");

    // scalar decode
    step(0, 0, 1, 3'b100, 1, 3'b000, 0, 0, 6'b000111, 2'b00, 3'd0, 4'b0000, "addi");
    step(0, 0, 1, 3'b000, 0, 3'b011, 0, 0, 6'b000111, 2'b11, 3'd0, 4'b0000, "shift");
    step(0, 0, 1, 3'b000, 0, 3'b000, 0, 0, 6'b000011, 2'b00, 3'd0, 4'b0000, "rtype");
    step(0, 0, 1, 3'b011, 0, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0001, "illegal");
    step(0, 0, 1, 3'b101, 0, 3'b000, 0, 0, 6'b100100, 2'b00, 3'd0, 4'b0000, "bgt");
    step(0, 0, 1, 3'b111, 1, 3'b000, 0, 0, 6'b100100, 2'b01, 3'd0, 4'b0000, "b");
    step(0, 0, 1, 3'b111, 0, 3'b000, 0, 0, 6'b100100, 2'b00, 3'd0, 4'b0000, "beq");
    step(0, 0, 1, 3'b001, 0, 3'b000, 0, 0, 6'b001100, 2'b00, 3'd0, 4'b0000, "str");
    step(0, 0, 1, 3'b010, 0, 3'b000, 0, 0, 6'b010110, 2'b00, 3'd0, 4'b0000, "ldr");
    step(0, 0, 1, 3'b000, 1, 3'b111, 0, 0, 6'b000111, 2'b11, 3'd0, 4'b0000, "vshift_scalar");

    // vldr, mem_ready low twice at lane 2; decode inputs ignored mid-sequence
    step(0, 0, 1, 3'b010, 1, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0100, "vldr_launch");
    step(0, 0, 0, 3'b000, 0, 3'b000, 1, 0, 6'b010110, 2'b00, 3'd0, 4'b1100, "vldr_l0");
    step(0, 0, 1, 3'b011, 0, 3'b000, 1, 0, 6'b010110, 2'b00, 3'd1, 4'b1100, "vldr_l1_ignore");
    step(0, 0, 0, 3'b000, 0, 3'b000, 0, 0, 6'b010100, 2'b00, 3'd2, 4'b1100, "vldr_l2_wait0");
    step(0, 0, 0, 3'b000, 0, 3'b000, 0, 0, 6'b010100, 2'b00, 3'd2, 4'b1100, "vldr_l2_wait1");
    step(0, 0, 0, 3'b000, 0, 3'b000, 1, 0, 6'b010110, 2'b00, 3'd2, 4'b1100, "vldr_l2");
    step(0, 0, 0, 3'b000, 0, 3'b000, 1, 0, 6'b010110, 2'b00, 3'd3, 4'b1100, "vldr_l3");
    step(0, 0, 0, 3'b000, 0, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0010, "vldr_done");
    step(0, 0, 1, 3'b100, 1, 3'b000, 0, 0, 6'b000111, 2'b00, 3'd0, 4'b0000, "post_done_addi");

    // vstr interrupted by reset at lane 1
    step(0, 0, 1, 3'b001, 1, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0100, "vstr_launch");
    step(0, 0, 0, 3'b000, 0, 3'b000, 1, 0, 6'b001100, 2'b00, 3'd0, 4'b1100, "vstr_l0");
    step(0, 1, 0, 3'b000, 0, 3'b000, 1, 0, 6'b000000, 2'b00, 3'd0, 4'b0000, "vstr_rst");
    step(0, 0, 0, 3'b000, 0, 3'b000, 1, 0, 6'b000000, 2'b00, 3'd0, 4'b0000, "after_rst_idle");

`ifdef VEC_ABORT_EN
    // abort wins over mem_ready at lane 2
    step(0, 0, 1, 3'b001, 1, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0100, "ab_launch");
    step(0, 0, 0, 3'b000, 0, 3'b000, 1, 0, 6'b001100, 2'b00, 3'd0, 4'b1100, "ab_l0");
    step(0, 0, 0, 3'b000, 0, 3'b000, 1, 0, 6'b001100, 2'b00, 3'd1, 4'b1100, "ab_l1");
    step(0, 0, 0, 3'b000, 0, 3'b000, 1, 1, 6'b000100, 2'b00, 3'd2, 4'b1100, "ab_kill");
    step(0, 0, 0, 3'b000, 0, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0000, "ab_idle");
`endif

    // dut b: 8-lane vector add, two lanes per beat
    step(1, 0, 1, 3'b000, 1, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0100, "vadd_launch");
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 6'b000011, 2'b00, 3'(2 * i), 4'b1100, "vadd_beat");
    step(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0010, "vadd_done");
    step(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0000, "vadd_idle");

    // dut b: 8-lane vstr without stalls, last lane exits to DONE
    step(1, 0, 1, 3'b001, 1, 3'b000, 1, 0, 6'b000000, 2'b00, 3'd0, 4'b0100, "vstr8_launch");
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 3'b000, 0, 3'b000, 1, 0, 6'b001100, 2'b00, 3'(i), 4'b1100, "vstr8_lane");
    step(1, 0, 0, 3'b000, 0, 3'b000, 1, 0, 6'b000000, 2'b00, 3'd0, 4'b0010, "vstr8_done");
    step(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 6'b000000, 2'b00, 3'd0, 4'b0000, "vstr8_idle");

    @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending expected 0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
